// File: rtl/hub75_frame_buffer.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : hub75_frame_buffer
// Description : Double-buffered HUB-75 pixel store. Raster writes fill the back
//               buffer and the scan driver reads bit-planes from the front one.
//               Optional write-path gamma stage: define HUB75_FB_GAMMA_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hub75_frame_buffer #(
    parameter int WIDTH      = 64,
    parameter int HEIGHT     = 64,
    parameter int COLOR_BITS = 5
) (
    input  logic                                                   clock,
    input  logic                                                   reset,
    input  logic                                                   wr_valid,
    output logic                                                   wr_ready,
    input  logic                                                   wr_sof,
    input  logic [3*COLOR_BITS-1:0]                                wr_data,
    input  logic                                                   rd_frame_start,
    input  logic                                                   rd_en,
    input  logic [$clog2(WIDTH)-1:0]                               rd_x,
    input  logic [$clog2(HEIGHT/2)-1:0]                            rd_row,
    input  logic [((COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1)-1:0] rd_plane,
    output logic                                                   rd_valid,
    output logic                                                   r1,
    output logic                                                   g1,
    output logic                                                   b1,
    output logic                                                   r2,
    output logic                                                   g2,
    output logic                                                   b2,
    output logic                                                   frame_swapped
);

    localparam int c_xw    = $clog2(WIDTH);
    localparam int c_yw    = $clog2(HEIGHT);
    localparam int c_rw    = $clog2(HEIGHT / 2);
    localparam int c_pw    = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
    localparam int c_dw    = 3 * COLOR_BITS;
    localparam int c_aw    = 1 + c_rw + c_xw;
    localparam int c_depth = 1 << c_aw;

    // Each half-panel memory holds both buffers; the MSB of the address is the buffer
    logic [c_dw-1:0] r_mem_upper [0:c_depth-1];
    logic [c_dw-1:0] r_mem_lower [0:c_depth-1];

    logic            r_front_sel;
    logic            r_rd_front_sel;
    logic            r_back_full;
    logic [c_xw-1:0] r_wx;
    logic [c_yw-1:0] r_wy;

    logic            w_accept;
    logic            w_last;
    logic            w_swap;
    logic            w_set_full;
    logic [c_xw-1:0] w_px;
    logic [c_yw-1:0] w_py;
    logic [c_aw-1:0] w_wr_addr;
    logic            w_wr_lower;

    logic            w_mem_we;
    logic            w_mem_lower;
    logic [c_aw-1:0] w_mem_addr;
    logic [c_dw-1:0] w_mem_data;

    logic [c_aw-1:0] w_rd_addr;
    logic [c_dw-1:0] r_rd_word_u;
    logic [c_dw-1:0] r_rd_word_l;
    logic            r_rd_v1;
    logic [c_pw-1:0] r_rd_plane1;

    // ------------------------------------------------------------------------
    // Write addressing
    // ------------------------------------------------------------------------
    assign w_accept   = wr_valid && wr_ready;
    assign w_px       = wr_sof ? '0 : r_wx;
    assign w_py       = wr_sof ? '0 : r_wy;
    assign w_last     = (w_px == c_xw'(WIDTH - 1)) && (w_py == c_yw'(HEIGHT - 1));
    assign w_wr_addr  = {~r_front_sel, w_py[c_rw-1:0], w_px};
    assign w_wr_lower = w_py[c_yw-1];
    assign w_swap     = rd_frame_start && r_back_full;

    // Power-of-two dimensions let both counters wrap to zero on the final pixel
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wx <= '0;
            r_wy <= '0;
        end else if (w_accept) begin
            r_wx <= w_px + c_xw'(1);
            if (w_px == c_xw'(WIDTH - 1)) begin
                r_wy <= w_py + c_yw'(1);
            end else begin
                r_wy <= w_py;
            end
        end
    end

`ifdef HUB75_FB_GAMMA_EN
    localparam int c_gw = 2 * COLOR_BITS + 1;

    function automatic logic [COLOR_BITS-1:0] gamma_ch(input logic [COLOR_BITS-1:0] c);
        logic [c_gw-1:0] v;
        v = (c_gw'(c) * c_gw'(c) + c_gw'((1 << COLOR_BITS) - 1)) >> COLOR_BITS;
        if (v > c_gw'((1 << COLOR_BITS) - 1)) begin
            gamma_ch = '1;
        end else begin
            gamma_ch = v[COLOR_BITS-1:0];
        end
    endfunction

    logic            r_g_valid;
    logic            r_g_last;
    logic            r_g_lower;
    logic            r_last_pending;
    logic [c_aw-1:0] r_g_addr;
    logic [c_dw-1:0] r_g_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_g_valid      <= 1'b0;
            r_g_last       <= 1'b0;
            r_g_lower      <= 1'b0;
            r_g_addr       <= '0;
            r_g_data       <= '0;
            r_last_pending <= 1'b0;
        end else begin
            r_g_valid <= w_accept;
            r_g_last  <= w_accept && w_last;
            if (w_accept) begin
                r_g_addr  <= w_wr_addr;
                r_g_lower <= w_wr_lower;
                r_g_data  <= wr_data;
            end
            // Hold off further pixels until the final write has committed
            if (w_accept && w_last) begin
                r_last_pending <= 1'b1;
            end else if (r_g_valid && r_g_last) begin
                r_last_pending <= 1'b0;
            end
        end
    end

    assign wr_ready    = !(r_back_full || r_last_pending);
    assign w_set_full  = r_g_valid && r_g_last;
    assign w_mem_we    = r_g_valid;
    assign w_mem_lower = r_g_lower;
    assign w_mem_addr  = r_g_addr;
    assign w_mem_data  = {gamma_ch(r_g_data[3*COLOR_BITS-1:2*COLOR_BITS]),
                          gamma_ch(r_g_data[2*COLOR_BITS-1:COLOR_BITS]),
                          gamma_ch(r_g_data[COLOR_BITS-1:0])};
`else
    assign wr_ready    = !r_back_full;
    assign w_set_full  = w_accept && w_last;
    assign w_mem_we    = w_accept;
    assign w_mem_lower = w_wr_lower;
    assign w_mem_addr  = w_wr_addr;
    assign w_mem_data  = wr_data;
`endif

    // ------------------------------------------------------------------------
    // Buffer ownership
    // ------------------------------------------------------------------------
    // The read-side select lags by one cycle so reads issued alongside the
    // swap and in the cycle after it still see the outgoing frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_front_sel    <= 1'b0;
            r_rd_front_sel <= 1'b0;
            r_back_full    <= 1'b0;
            frame_swapped  <= 1'b0;
        end else begin
            frame_swapped  <= w_swap;
            r_rd_front_sel <= r_front_sel;
            if (w_swap) begin
                r_front_sel <= ~r_front_sel;
                r_back_full <= 1'b0;
            end else if (w_set_full) begin
                r_back_full <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Memories
    // ------------------------------------------------------------------------
    assign w_rd_addr = {r_rd_front_sel, rd_row, rd_x};

    always_ff @(posedge clock) begin
        if (w_mem_we && !w_mem_lower) begin
            r_mem_upper[w_mem_addr] <= w_mem_data;
        end
        if (rd_en) begin
            r_rd_word_u <= r_mem_upper[w_rd_addr];
        end
    end

    always_ff @(posedge clock) begin
        if (w_mem_we && w_mem_lower) begin
            r_mem_lower[w_mem_addr] <= w_mem_data;
        end
        if (rd_en) begin
            r_rd_word_l <= r_mem_lower[w_rd_addr];
        end
    end

    // ------------------------------------------------------------------------
    // Bit-plane select
    // ------------------------------------------------------------------------
    // Planes at or beyond COLOR_BITS match no index and yield zeros
    function automatic logic [2:0] select_bits(input logic [c_dw-1:0] word,
                                               input logic [c_pw-1:0] plane);
        select_bits = 3'b000;
        for (int i = 0; i < COLOR_BITS; i++) begin
            if (plane == c_pw'(i)) begin
                select_bits = {word[2*COLOR_BITS+i], word[COLOR_BITS+i], word[i]};
            end
        end
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_v1     <= 1'b0;
            r_rd_plane1 <= '0;
            rd_valid    <= 1'b0;
            r1          <= 1'b0;
            g1          <= 1'b0;
            b1          <= 1'b0;
            r2          <= 1'b0;
            g2          <= 1'b0;
            b2          <= 1'b0;
        end else begin
            r_rd_v1  <= rd_en;
            rd_valid <= r_rd_v1;
            if (rd_en) begin
                r_rd_plane1 <= rd_plane;
            end
            if (r_rd_v1) begin
                {r1, g1, b1} <= select_bits(r_rd_word_u, r_rd_plane1);
                {r2, g2, b2} <= select_bits(r_rd_word_l, r_rd_plane1);
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/hub75_frame_buffer.md
# hub75_frame_buffer

Double-buffered pixel store that sits directly upstream of the HUB-75 scan driver. A raster-order pixel stream from the host or pattern generator fills the back buffer. The driver reads the front buffer by column, row pair and bit-plane, and gets back the six serial colour bits r1/g1/b1/r2/g2/b2 for the upper and lower panel halves. Buffers swap only at a driver frame boundary, so a frame is never displayed half-written.

## Interface
Parameters:
- WIDTH, 64, panel columns (power of two)
- HEIGHT, 64, panel rows (power of two); scan rows = HEIGHT/2
- COLOR_BITS, 5, bits per colour channel = number of BCM bit-planes

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high
- wr_valid  input  1  pixel on wr_data is valid
- wr_ready  output  1  block accepts pixel this cycle
- wr_sof  input  1  accepted pixel is pixel (0,0) of a new frame
- wr_data  input  3*COLOR_BITS  pixel {r,g,b}, r in MSBs
- rd_frame_start  input  1  one-cycle pulse from driver at start of a display frame
- rd_en  input  1  read request
- rd_x  input  log2(WIDTH)  column
- rd_row  input  log2(HEIGHT/2)  scan row; the upper half reads row rd_row, the lower half reads rd_row+HEIGHT/2
- rd_plane  input  log2(COLOR_BITS) (min 1)  bit-plane index, 0 = LSB
- rd_valid  output  1  r1..b2 valid
- r1, g1, b1, r2, g2, b2  output  1 each  selected bit of the upper (1) and lower (2) pixel
- frame_swapped  output  1  one-cycle pulse when front/back exchanged

## Operation
- Storage: 2 buffers × 2 halves (upper/lower) × WIDTH*HEIGHT/2 words of 3*COLOR_BITS. The two halves are separate memories, so both pixels are read in the same cycle. Contents are not reset.
- State: front_sel (1 bit), back_full (1 bit), write counters wx and wy.
- Write path:
  - A pixel is accepted when wr_valid && wr_ready.
  - wr_ready = !back_full.
  - An accepted pixel is written to the back buffer at (wx, wy). If wy < HEIGHT/2 it goes to the upper memory at row wy; otherwise it goes to the lower memory at row wy-HEIGHT/2.
  - wr_sof on an accepted pixel forces that pixel to (0,0) and the counters continue from there. A partial frame in progress is discarded without further effect.
  - wx increments and wraps at WIDTH-1; wy increments on the wx wrap.
  - Acceptance of pixel (WIDTH-1, HEIGHT-1) sets back_full, wraps both counters to 0, and drops wr_ready from the next cycle.
- Swap:
  - Occurs on rd_frame_start with back_full=1: front_sel toggles, back_full clears, frame_swapped pulses in the following cycle.
  - rd_frame_start with back_full=0 has no effect; the front frame repeats.
- Read path:
  - rd_en samples rd_x, rd_row and rd_plane.
  - The front buffer memories are read and the selected bit of each channel is registered to the outputs.
  - If rd_plane >= COLOR_BITS, all six colour outputs are 0.
  - rd_valid follows rd_en with the same latency.
  - When rd_en=0, the colour outputs hold their last value.

## Timing
- Reset values: wr_ready=1, back_full=0, front_sel=0, wx=wy=0, rd_valid=0, frame_swapped=0, all colour outputs 0.
- Read latency: 2 cycles from rd_en to rd_valid/data (memory register, then bit-select register). The read path is fully pipelined and accepts one read per cycle.
- Write latency: 1 cycle from acceptance to the memory write.
- A read in the same or the following cycle as a swap still returns the old front buffer. front_sel used for a read is sampled together with rd_en.
- Final pixel accepted in the same cycle as rd_frame_start: no swap. back_full becomes 1 the next cycle and the swap occurs at the next rd_frame_start.
- Reset mid-frame: the partial frame is lost, writing restarts at (0,0) of buffer 1 (back), and the read pipeline is flushed (rd_valid=0).

## Configuration
- HUB75_FB_GAMMA_EN defined:
  - A gamma stage on the write path maps each channel c to (c*c + (2^COLOR_BITS-1)) >> COLOR_BITS, saturating at 2^COLOR_BITS-1.
  - Any nonzero c maps to at least 1; c=0 maps to 0.
  - The stage adds one register stage, so write latency is 2 cycles.
  - wr_ready and all counter and swap behaviour are unchanged; the final-pixel back_full update waits for the pipelined write.
- Undefined: pixels are stored unmodified, with a 1-cycle write latency.

## Test plan
- Reset, then check idle outputs -> wr_ready=1, rd_valid=0, frame_swapped=0, r1..b2=0.
- Fill 4096 pixels with r=x[4:0], g=y[4:0], b=0, then pulse rd_frame_start -> frame_swapped pulses 1 cycle later. rd_x=3, rd_row=5, rd_plane=1 gives rd_valid 2 cycles later with r1=1 (x=3), g1=0 (y=5), r2=1, g2=0 (y=37, bit1=0).
- After a full back buffer with no rd_frame_start -> wr_ready=0 and further wr_valid pixels are not accepted; after rd_frame_start, wr_ready=1 the next cycle.
- Final pixel accepted in the same cycle as rd_frame_start -> no frame_swapped; the next rd_frame_start swaps.
- wr_sof asserted at pixel 100 of a partial frame, then a full 4096-pixel frame -> swap occurs after exactly 4096 pixels counted from the sof pixel.
- Reset asserted mid-frame with reads in flight -> rd_valid deasserts immediately, wr_ready=1, and the next frame starts at (0,0).
